// File: rtl/gumnut_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between Gumnut fetch (m0)
// and data (m1) masters. The grant is locked for the length of a master's cyc.
//
// Ports: clk and rst (synchronous, active high).
//   m0_*  : fetch master. It is read-only.
//   m1_*  : data master.
//   s_*   : shared slave port.
//   grant_o : one-hot current grant (bit0 = m0, bit1 = m1).
// Optional feature: define ARB_TIMEOUT_EN to abort transfers that are never
// acked after TIMEOUT strobe cycles. Without it, the err outputs stay 0.
module gumnut_bus_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 18,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  output logic [DATA_W-1:0] m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [DATA_W-1:0] s_dat_o,
  input  logic [DATA_W-1:0] s_dat_i,
  input  logic              s_ack_i,
  output logic [1:0]        grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t     state_q;
  logic       last_q;   // 0 = m0, 1 = m1 was granted most recently
  logic [1:0] grant_q;
  logic       g0, g1;
  logic       to_w;     // watchdog abort in this cycle

  assign g0 = (state_q == GNT0);
  assign g1 = (state_q == GNT1);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       leave_w;

  assign to_w    = (g0 | g1) && (cnt_q == 8'(TIMEOUT));
  assign leave_w = (g0 & ~m0_cyc_i) | (g1 & ~m1_cyc_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else if (!(g0 | g1) || s_ack_i || to_w || leave_w) begin
      cnt_q <= 8'd0;
    end else if (s_stb_o) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end
`else
  assign to_w = 1'b0;
`endif

  // On a tie, the master that was not granted last wins.
  // After a timeout, last already names the aborted master,
  // so a waiting peer wins the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      grant_q <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
            state_q <= GNT0;
            last_q  <= 1'b0;
            grant_q <= 2'b01;
          end else if (m1_cyc_i) begin
            state_q <= GNT1;
            last_q  <= 1'b1;
            grant_q <= 2'b10;
          end
        end
        GNT0: begin
          if (!m0_cyc_i || to_w) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
          end
        end
        GNT1: begin
          if (!m1_cyc_i || to_w) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (g0 && !to_w) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_adr_o = m0_adr_i;
    end else if (g1 && !to_w) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & g0 & ~to_w;
  assign m1_ack_o = s_ack_i & g1 & ~to_w;
  assign m0_err_o = to_w & g0;
  assign m1_err_o = to_w & g1;
  assign grant_o  = grant_q;

endmodule

// File: tb/tb_gumnut_bus_arbiter.sv
// Directed bench for gumnut_bus_arbiter.
// Uses per-cycle vectors plus a watchdog sequence.
module tb_gumnut_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_cyc_i = 0, m0_stb_i = 0;
  logic [11:0] m0_adr_i = 0;
  logic [17:0] m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [11:0] m1_adr_i = 0;
  logic [17:0] m1_dat_i = 0;
  logic [17:0] m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [11:0] s_adr_o;
  logic [17:0] s_dat_o;
  logic [17:0] s_dat_i = 0;
  logic        s_ack_i = 0;
  logic [1:0]  grant_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gumnut_bus_arbiter #(.ADDR_W(12), .DATA_W(18), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_adr_i(m0_adr_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o)
  );

  typedef struct {
    logic        rst;
    logic        c0, s0;
    logic [11:0] a0;
    logic        c1, s1, w1;
    logic [11:0] a1;
    logic [17:0] d1;
    logic [17:0] sd;
    logic        sa;
    logic [1:0]  eg;
    logic        ec, es, ew;
    logic [11:0] ea;
    logic [17:0] ed;
    logic        k0, k1;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    logic r, logic c0, logic s0, logic [11:0] a0,
    logic c1, logic s1, logic w1, logic [11:0] a1, logic [17:0] d1,
    logic [17:0] sd, logic sa,
    logic [1:0] eg, logic ec, logic es, logic ew,
    logic [11:0] ea, logic [17:0] ed, logic k0, logic k1);
    vec_t v;
    v.rst = r; v.c0 = c0; v.s0 = s0; v.a0 = a0;
    v.c1 = c1; v.s1 = s1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.sd = sd; v.sa = sa;
    v.eg = eg; v.ec = ec; v.es = es; v.ew = ew;
    v.ea = ea; v.ed = ed; v.k0 = k0; v.k1 = k1;
    return v;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {grant_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
            m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o};
  endfunction

  task automatic drive_zero();
    m0_cyc_i = 0; m0_stb_i = 0; m0_adr_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
    m1_adr_i = 0; m1_dat_i = 0; s_dat_i = 0; s_ack_i = 0;
  endtask

  initial begin
    logic [127:0] ex;
    logic         w;
    logic         e;

    // Single m0 read, with a stray ack in IDLE
    vq.push_back(mk(0, 0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0,0,0,0));
    vq.push_back(mk(0, 1,1,'h010, 0,0,0,0,0, 0,1,
                    0,0,0,0,0,0,0,0));
    vq.push_back(mk(0, 1,1,'h010, 0,0,1,'h3AA,'h3FFFF, 0,0,
                    1,1,1,0,'h010,0,0,0));
    vq.push_back(mk(0, 1,1,'h010, 0,0,1,'h3AA,'h3FFFF, 0,0,
                    1,1,1,0,'h010,0,0,0));
    vq.push_back(mk(0, 1,1,'h010, 0,0,0,0,0, 'h2A5F0,1,
                    1,1,1,0,'h010,0,1,0));
    vq.push_back(mk(0, 0,0,0, 0,0,0,0,0, 0,0, 1,0,0,0,0,0,0,0));
    vq.push_back(mk(0, 0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0,0,0,0));
    vq.push_back(mk(1, 0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0,0,0,0));
    // Four tie rounds, alternating m0 / m1
    for (int r = 0; r < 4; r++) begin
      w = r[0];
      vq.push_back(mk(0, 1,1,'h111, 1,1,0,'h222,'h33, 0,0,
                      0,0,0,0,0,0,0,0));
      if (!w)
        vq.push_back(mk(0, 1,1,'h111, 1,1,0,'h222,'h33, 'h1234,1,
                        1,1,1,0,'h111,0,1,0));
      else
        vq.push_back(mk(0, 1,1,'h111, 1,1,0,'h222,'h33, 'h1234,1,
                        2,1,1,0,'h222,'h33,0,1));
      vq.push_back(mk(0, 0,0,0, 0,0,0,0,0, 0,0,
                      w ? 2'd2 : 2'd1, 0,0,0,0,0,0,0));
    end
    // m0 locks for 3 fetches while m1 waits with a write
    vq.push_back(mk(0, 1,1,'h040, 1,1,1,'h0FF,'h0C5, 0,0,
                    0,0,0,0,0,0,0,0));
    vq.push_back(mk(0, 1,1,'h040, 1,1,1,'h0FF,'h0C5, 'h15555,1,
                    1,1,1,0,'h040,0,1,0));
    vq.push_back(mk(0, 1,1,'h041, 1,1,1,'h0FF,'h0C5, 0,0,
                    1,1,1,0,'h041,0,0,0));
    vq.push_back(mk(0, 1,1,'h041, 1,1,1,'h0FF,'h0C5, 'h00001,1,
                    1,1,1,0,'h041,0,1,0));
    vq.push_back(mk(0, 1,1,'h042, 1,1,1,'h0FF,'h0C5, 0,0,
                    1,1,1,0,'h042,0,0,0));
    vq.push_back(mk(0, 1,1,'h042, 1,1,1,'h0FF,'h0C5, 'h00002,1,
                    1,1,1,0,'h042,0,1,0));
    vq.push_back(mk(0, 0,0,0, 1,1,1,'h0FF,'h0C5, 0,0,
                    1,0,0,0,0,0,0,0));
    vq.push_back(mk(0, 0,0,0, 1,1,1,'h0FF,'h0C5, 0,1,
                    0,0,0,0,0,0,0,0));
    vq.push_back(mk(0, 0,0,0, 1,1,1,'h0FF,'h0C5, 0,1,
                    2,1,1,1,'h0FF,'h0C5,0,1));
    vq.push_back(mk(0, 0,0,0, 0,0,0,0,0, 0,0, 2,0,0,0,0,0,0,0));
    vq.push_back(mk(0, 0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0,0,0,0));
    // Reset during GNT1, then tie goes to m0
    vq.push_back(mk(0, 0,0,0, 1,1,0,'h123,'h777, 0,0,
                    0,0,0,0,0,0,0,0));
    vq.push_back(mk(1, 0,0,0, 1,1,0,'h123,'h777, 0,0,
                    2,1,1,0,'h123,'h777,0,0));
    vq.push_back(mk(0, 1,1,'h321, 1,1,0,'h123,'h777, 0,1,
                    0,0,0,0,0,0,0,0));
    vq.push_back(mk(0, 1,1,'h321, 1,1,0,'h123,'h777, 0,0,
                    1,1,1,0,'h321,0,0,0));
    vq.push_back(mk(0, 0,0,0, 0,0,0,0,0, 0,0, 1,0,0,0,0,0,0,0));
    vq.push_back(mk(0, 0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0,0,0,0));

    rst = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst;
      m0_cyc_i = vq[i].c0; m0_stb_i = vq[i].s0; m0_adr_i = vq[i].a0;
      m1_cyc_i = vq[i].c1; m1_stb_i = vq[i].s1; m1_we_i = vq[i].w1;
      m1_adr_i = vq[i].a1; m1_dat_i = vq[i].d1;
      s_dat_i = vq[i].sd; s_ack_i = vq[i].sa;
      #1;
      ex = {vq[i].eg, vq[i].ec, vq[i].es, vq[i].ew, vq[i].ea, vq[i].ed,
            vq[i].k0, vq[i].k1, 1'b0, 1'b0, vq[i].sd, vq[i].sd};
      chk($sformatf("vec%0d", i), outs(), ex);
    end

    // Watchdog: m1 strobe never acked, m0 arrives and waits
    @(negedge clk);
    drive_zero();
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 'h055;
    #1;
    chk("wd_idle", {126'd0, grant_o}, {126'd0, 2'b00});
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 1) begin
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 'h0AA;
      end
      #1;
      e = (k == 15);
      chk($sformatf("wd_k%0d", k),
          {121'd0, grant_o, m1_err_o, m0_err_o, m1_ack_o, s_stb_o, s_cyc_o},
          {121'd0, 2'b10, e, 1'b0, 1'b0, ~e, ~e});
    end
    @(negedge clk);
    s_ack_i = 1;
    #1;
    chk("wd_late_ack",
        {123'd0, grant_o, m1_err_o, m1_ack_o, m0_ack_o},
        {123'd0, 2'b00, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    s_ack_i = 0;
    #1;
    chk("wd_m0_next", {114'd0, grant_o, s_adr_o}, {114'd0, 2'b01, 12'h0AA});
`else
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 1) begin
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 'h0AA;
      end
      #1;
      chk($sformatf("hold_k%0d", k),
          {123'd0, grant_o, m1_err_o, m0_err_o, s_stb_o},
          {123'd0, 2'b10, 1'b0, 1'b0, 1'b1});
    end
`endif
    @(negedge clk);
    drive_zero();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
